// File: rtl/stall_controller.sv
// Pipeline interlock controller for the five-stage core: drives per-stage enables
// and NOP-insert strobes from hazard, redirect and memory handshakes, plus perf counters.
module stall_controller #(
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubble,
    input  logic             flush,
    input  logic             imem_resp_valid,
    input  logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    input  logic             mem_resp_wait,
    input  logic             dmem_resp_valid,
    output logic             if_en,
    output logic             ex_en,
    output logic             mem_req_en,
    output logic             mem_resp_en,
    output logic             wb_en,
    output logic             if_kill,
    output logic             ex_kill,
    output logic [CNT_W-1:0] mem_stall_cycles,
    output logic [CNT_W-1:0] bubble_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_stall_events
);

    localparam logic [1:0] S_HOLD   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_MSTALL = 2'd2;

    localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_flush_shadow;
    logic [CNT_W-1:0]  r_mem_stall_cycles;
    logic [CNT_W-1:0]  r_bubble_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic [CNT_W-1:0]  r_mem_stall_events;

    logic       w_mstall;
    logic [1:0] w_state_nxt;
    logic       w_shadow_nxt;
    logic       w_inc_stall;
    logic       w_inc_event;
    logic       w_inc_bubble;
    logic       w_inc_flush;
    logic       w_if_en;
    logic       w_ex_en;
    logic       w_mem_req_en;
    logic       w_mem_resp_en;
    logic       w_wb_en;
    logic       w_if_kill;
    logic       w_ex_kill;

    assign w_mstall = (dmem_req_valid & ~dmem_req_ready) | (mem_resp_wait & ~dmem_resp_valid);

    // Mealy output decode and next-state selection; defaults are the HOLD drain values
    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_flush_shadow;
        w_inc_stall   = 1'b0;
        w_inc_event   = 1'b0;
        w_inc_bubble  = 1'b0;
        w_inc_flush   = 1'b0;
        w_if_en       = 1'b0;
        w_ex_en       = 1'b1;
        w_mem_req_en  = 1'b1;
        w_mem_resp_en = 1'b1;
        w_wb_en       = 1'b1;
        w_if_kill     = 1'b1;
        w_ex_kill     = 1'b1;
        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_RUN, S_MSTALL: begin
                w_ex_kill = 1'b0;
                if (w_mstall) begin
                    w_if_en       = 1'b0;
                    w_ex_en       = 1'b0;
                    w_mem_req_en  = 1'b0;
                    w_mem_resp_en = 1'b0;
                    w_wb_en       = 1'b0;
                    w_if_kill     = 1'b0;
                    w_inc_stall   = 1'b1;
                    w_inc_event   = (r_state == S_RUN);
                    w_state_nxt   = S_MSTALL;
                end else if (bubble) begin
                    // EX is held, so a concurrent flush is re-presented next cycle
                    w_ex_en      = 1'b0;
                    w_if_kill    = 1'b0;
                    w_ex_kill    = 1'b1;
                    w_inc_bubble = 1'b1;
                    w_state_nxt  = S_RUN;
                end else if (flush) begin
                    w_if_en      = 1'b1;
                    w_shadow_nxt = 1'b1;
                    w_inc_flush  = 1'b1;
                    w_state_nxt  = S_RUN;
                end else begin
                    w_if_en      = imem_resp_valid;
                    w_if_kill    = r_flush_shadow | ~imem_resp_valid;
                    w_shadow_nxt = 1'b0;
                    w_state_nxt  = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    assign if_en       = rst_n ? w_if_en       : 1'b0;
    assign ex_en       = rst_n ? w_ex_en       : 1'b1;
    assign mem_req_en  = rst_n ? w_mem_req_en  : 1'b1;
    assign mem_resp_en = rst_n ? w_mem_resp_en : 1'b1;
    assign wb_en       = rst_n ? w_wb_en       : 1'b1;
    assign if_kill     = rst_n ? w_if_kill     : 1'b1;
    assign ex_kill     = rst_n ? w_ex_kill     : 1'b1;

    // State, drain counter, wrong-path shadow and wrapping performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= S_HOLD;
            r_hold_cnt         <= {HOLD_W{1'b0}};
            r_flush_shadow     <= 1'b0;
            r_mem_stall_cycles <= {CNT_W{1'b0}};
            r_bubble_cycles    <= {CNT_W{1'b0}};
            r_flush_count      <= {CNT_W{1'b0}};
            r_mem_stall_events <= {CNT_W{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_flush_shadow <= w_shadow_nxt;
            if (r_state == S_HOLD && w_state_nxt == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end else begin
                r_hold_cnt <= {HOLD_W{1'b0}};
            end
            if (w_inc_stall) begin
                r_mem_stall_cycles <= r_mem_stall_cycles + CNT_ONE;
            end else begin
                r_mem_stall_cycles <= r_mem_stall_cycles;
            end
            if (w_inc_event) begin
                r_mem_stall_events <= r_mem_stall_events + CNT_ONE;
            end else begin
                r_mem_stall_events <= r_mem_stall_events;
            end
            if (w_inc_bubble) begin
                r_bubble_cycles <= r_bubble_cycles + CNT_ONE;
            end else begin
                r_bubble_cycles <= r_bubble_cycles;
            end
            if (w_inc_flush) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign mem_stall_cycles = r_mem_stall_cycles;
    assign bubble_cycles    = r_bubble_cycles;
    assign flush_count      = r_flush_count;
    assign mem_stall_events = r_mem_stall_events;

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench for stall_controller: directed scenarios plus randomized traffic,
// compared every cycle against a rule-level model of enables, kills and counters.
module tb_stall_controller;

    localparam int RH  = 2;
    localparam int CW  = 4;
    localparam int MOD = 16;

    localparam logic [6:0] O_HOLD   = 7'b0111111;
    localparam logic [6:0] O_RUN    = 7'b1111100;
    localparam logic [6:0] O_STALL  = 7'b0000000;
    localparam logic [6:0] O_BUBBLE = 7'b0011101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, bubble, flush, imem_resp_valid;
    logic dmem_req_valid, dmem_req_ready, mem_resp_wait, dmem_resp_valid;
    logic if_en, ex_en, mem_req_en, mem_resp_en, wb_en, if_kill, ex_kill;
    logic [CW-1:0] mem_stall_cycles, bubble_cycles, flush_count, mem_stall_events;

    stall_controller #(.RESET_HOLD(RH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush),
        .imem_resp_valid(imem_resp_valid), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .mem_resp_wait(mem_resp_wait),
        .dmem_resp_valid(dmem_resp_valid), .if_en(if_en), .ex_en(ex_en),
        .mem_req_en(mem_req_en), .mem_resp_en(mem_resp_en), .wb_en(wb_en),
        .if_kill(if_kill), .ex_kill(ex_kill), .mem_stall_cycles(mem_stall_cycles),
        .bubble_cycles(bubble_cycles), .flush_count(flush_count),
        .mem_stall_events(mem_stall_events)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: drain cycles left, whether last cycle was a memory stall,
    // pending wrong-path shadow, and unbounded event tallies (reduced mod 2^CW on compare).
    int m_hold_left, m_stall_cyc, m_bub, m_flush, m_events;
    bit m_stalled, m_shadow;
    logic [6:0] last_out;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    endtask

    function automatic bit model_mstall();
        return (dmem_req_valid && !dmem_req_ready) || (mem_resp_wait && !dmem_resp_valid);
    endfunction

    function automatic logic [6:0] model_out();
        if (!rst_n || m_hold_left > 0) return O_HOLD;
        if (model_mstall()) return O_STALL;
        if (bubble) return O_BUBBLE;
        if (flush) return 7'b1111110;
        return {imem_resp_valid, 4'b1111, m_shadow | !imem_resp_valid, 1'b0};
    endfunction

    task automatic model_reset();
        m_hold_left = RH;
        m_stall_cyc = 0; m_bub = 0; m_flush = 0; m_events = 0;
        m_stalled = 1'b0; m_shadow = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) model_reset();
        else if (m_hold_left > 0) m_hold_left--;
        else if (model_mstall()) begin
            m_stall_cyc++;
            if (!m_stalled) m_events++;
            m_stalled = 1'b1;
        end else begin
            m_stalled = 1'b0;
            if (bubble) m_bub++;
            else if (flush) begin m_flush++; m_shadow = 1'b1; end
            else m_shadow = 1'b0;
        end
    endtask

    // One clock: drive inputs, compare outputs and counters mid-cycle, then advance model.
    task automatic cycle(input logic r, input logic b, input logic f, input logic iv,
                         input logic qv, input logic qr, input logic rw, input logic rv);
        rst_n = r; bubble = b; flush = f; imem_resp_valid = iv;
        dmem_req_valid = qv; dmem_req_ready = qr; mem_resp_wait = rw; dmem_resp_valid = rv;
        #1;
        last_out = {if_en, ex_en, mem_req_en, mem_resp_en, wb_en, if_kill, ex_kill};
        chk("outputs", int'(last_out), int'(model_out()));
        chk("mem_stall_cycles", int'(mem_stall_cycles), m_stall_cyc % MOD);
        chk("bubble_cycles", int'(bubble_cycles), m_bub % MOD);
        chk("flush_count", int'(flush_count), m_flush % MOD);
        chk("mem_stall_events", int'(mem_stall_events), m_events % MOD);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(); cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask

    initial begin
        rst_n = 1'b0; bubble = 1'b0; flush = 1'b0; imem_resp_valid = 1'b1;
        dmem_req_valid = 1'b0; dmem_req_ready = 1'b0; mem_resp_wait = 1'b0; dmem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset release: two drain cycles, then normal fetch
        idle(); chk("hold_out_1", int'(last_out), int'(O_HOLD));
        idle(); chk("hold_out_2", int'(last_out), int'(O_HOLD));
        idle(); chk("run_out", int'(last_out), int'(O_RUN));
        chk("cnt_zero_after_hold", int'(bubble_cycles) + int'(flush_count), 0);

        // Three bubbles
        repeat (3) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bubble_out", int'(last_out), int'(O_BUBBLE));
        end
        chk("bubble_cycles_3", int'(bubble_cycles), 3);

        // Single flush then shadow
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_if_kill", int'(if_kill), 1);
        idle(); chk("shadow_out", int'(last_out), int'(7'b1111110));
        idle(); chk("after_shadow_out", int'(last_out), int'(O_RUN));
        chk("flush_count_1", int'(flush_count), 1);

        // Request stall dominating bubble and flush
        repeat (4) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("mstall_out", int'(last_out), int'(O_STALL));
        end
        chk("mem_stall_cycles_4", int'(mem_stall_cycles), 4);
        chk("mem_stall_events_1", int'(mem_stall_events), 1);
        chk("bubble_unchanged", int'(bubble_cycles), 3);
        chk("flush_unchanged", int'(flush_count), 1);

        // Flush, response stall, then shadow appears on first free cycle
        idle();
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("shadow_after_stall", int'(last_out), int'(7'b1111110));
        idle(); chk("shadow_cleared", int'(if_kill), 0);

        // Counter wrap and reset mid-bubble
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        repeat (17) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bubble_wrap", int'(bubble_cycles), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_mid_bubble_out", int'(last_out), int'(O_HOLD));
        chk("reset_clears_bubble", int'(bubble_cycles), 0);
        idle(); idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(199) != 0),
                  ($urandom_range(3) == 0), ($urandom_range(4) == 0),
                  ($urandom_range(4) != 0), ($urandom_range(2) == 0),
                  ($urandom_range(1) == 0), ($urandom_range(4) == 0),
                  ($urandom_range(1) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
